// File: rtl/sha512_job_scheduler_pkg.sv
// Shared types and constants for the SHA512 multi-client job scheduler.
package sha512_sched_pkg;

    // Scheduler control states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // SHA_Mode encodings understood by the core; anything else selects its default IV path
    localparam logic [31:0] SHA_MODE_224 = 32'd224;
    localparam logic [31:0] SHA_MODE_256 = 32'd256;
    localparam logic [31:0] SHA_MODE_512 = 32'd512;

endpackage

// File: rtl/sha512_job_scheduler_if.sv
// Client-side and core-control handshake bundle of the SHA512 job scheduler.
// The scheduler connects through the slave modport; the clients/core side
// (or a testbench standing in for them) uses the master modport.
interface sha512_job_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*32-1:0]    req_mode;
    logic [NUM_REQ*CNT_W-1:0] req_nblocks;
    logic [NUM_REQ-1:0]       blk_avail;
    logic [NUM_REQ-1:0]       blk_take;
    logic [NUM_REQ-1:0]       gnt;
    logic [IDX_W-1:0]         sel;
    logic                     core_sync;
    logic                     core_init;
    logic [31:0]              core_mode;
    logic                     core_done;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       err;

    modport master (
        output req, req_mode, req_nblocks, blk_avail, core_done,
        input  blk_take, gnt, sel, core_sync, core_init, core_mode, done, err
    );

    modport slave (
        input  req, req_mode, req_nblocks, blk_avail, core_done,
        output blk_take, gnt, sel, core_sync, core_init, core_mode, done, err
    );

endinterface

// File: rtl/sha512_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request after ptr, wrapping around.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan from ptr+1 upward (mod NUM_REQ); the first hit wins, later hits are masked by any
    always_comb begin
        int   cand_s;
        logic hit_s;
        cand_s = 0;
        hit_s  = 1'b0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_s = (int'(ptr) + i) % NUM_REQ;
            hit_s  = req[cand_s] & ~any;
            idx    = hit_s ? IDX_W'(cand_s) : idx;
            any    = any | req[cand_s];
        end
        gnt = NUM_REQ'(any) << idx;
    end

endmodule

// File: rtl/sha512_job_scheduler.sv
// Multi-client front-end for the SHA512 core: round-robin job arbitration,
// per-block issue with init on the first block, watchdog on core completion,
// and per-client done/err reporting.
module sha512_job_scheduler
    import sha512_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 127
) (
    input logic                   clk,
    input logic                   rst,
    sha512_job_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [NUM_REQ-1:0] ONE_V = NUM_REQ'(1);

    state_t               state_r, state_n;
    logic [NUM_REQ-1:0]   gnt_r, gnt_n;
    logic [IDX_W-1:0]     sel_r, sel_n;
    logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_n;
    logic [31:0]          mode_r, mode_n;
    logic [CNT_W-1:0]     remaining_r, remaining_n;
    logic                 first_r, first_n;
    logic [TMR_W-1:0]     timer_r, timer_n;
    logic [NUM_REQ-1:0]   done_r, done_n;
    logic [NUM_REQ-1:0]   err_r, err_n;

    logic [NUM_REQ-1:0]   arb_gnt_s;
    logic [IDX_W-1:0]     arb_idx_s;
    logic                 arb_any_s;
    logic [31:0]          win_mode_s;
    logic [CNT_W-1:0]     win_nblk_s;
    logic                 issue_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.req),
        .ptr (rr_ptr_r),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

    // Job parameters of the current arbitration winner and the issue strobe
    always_comb begin
        win_mode_s = bus.req_mode[int'(arb_idx_s)*32 +: 32];
        win_nblk_s = bus.req_nblocks[int'(arb_idx_s)*CNT_W +: CNT_W];
        issue_s    = (state_r == ISSUE) && bus.blk_avail[sel_r];
    end

    // Next-state and next-output logic of the job sequencer
    always_comb begin
        state_n     = state_r;
        gnt_n       = gnt_r;
        sel_n       = sel_r;
        rr_ptr_n    = rr_ptr_r;
        mode_n      = mode_r;
        remaining_n = remaining_r;
        first_n     = first_r;
        timer_n     = timer_r;
        case (state_r)
            IDLE: begin
                if (arb_any_s) begin
                    gnt_n       = arb_gnt_s;
                    sel_n       = arb_idx_s;
                    mode_n      = win_mode_s;
                    remaining_n = win_nblk_s;
                    first_n     = 1'b1;
                    if (win_nblk_s == '0) begin
                        state_n = ERR;
                    end else begin
                        state_n = ISSUE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (issue_s) begin
                    timer_n = '0;
                    state_n = WAIT;
                end else begin
                    state_n = ISSUE;
                end
            end
            WAIT: begin
                timer_n = timer_r + TMR_W'(1);
                // A completion in the timeout cycle still counts as success
                if (bus.core_done) begin
                    first_n = 1'b0;
                    if (remaining_r == CNT_W'(1)) begin
                        state_n = DONE;
                    end else begin
                        remaining_n = remaining_r - CNT_W'(1);
                        state_n     = ISSUE;
                    end
                end else if (timer_r == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_n = ERR;
                end else begin
                    state_n = WAIT;
                end
            end
            DONE, ERR: begin
                gnt_n    = '0;
                rr_ptr_n = sel_r;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Completion pulses are registered so they appear in the DONE/ERR cycle
        done_n = '0;
        err_n  = '0;
        if (state_n == DONE) begin
            done_n = ONE_V << sel_n;
        end else if (state_n == ERR) begin
            err_n = ONE_V << sel_n;
        end else begin
            done_n = '0;
            err_n  = '0;
        end
    end

    // State and output registers; reset abandons any job in flight without an err pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            gnt_r       <= '0;
            sel_r       <= '0;
            rr_ptr_r    <= IDX_W'(NUM_REQ - 1);
            mode_r      <= '0;
            remaining_r <= '0;
            first_r     <= 1'b0;
            timer_r     <= '0;
            done_r      <= '0;
            err_r       <= '0;
        end else begin
            state_r     <= state_n;
            gnt_r       <= gnt_n;
            sel_r       <= sel_n;
            rr_ptr_r    <= rr_ptr_n;
            mode_r      <= mode_n;
            remaining_r <= remaining_n;
            first_r     <= first_n;
            timer_r     <= timer_n;
            done_r      <= done_n;
            err_r       <= err_n;
        end
    end

    // Drive the interface; sync and take follow the staged block combinationally
    always_comb begin
        bus.gnt       = gnt_r;
        bus.sel       = sel_r;
        bus.core_mode = mode_r;
        bus.core_init = first_r;
        bus.done      = done_r;
        bus.err       = err_r;
        bus.core_sync = issue_s;
        bus.blk_take  = issue_s ? (ONE_V << sel_r) : '0;
    end

endmodule

// File: doc/sha512_job_scheduler.md
Name: sha512_job_scheduler

Overview:
Multi-requester front-end for the SHA512 core. It arbitrates round-robin between NUM_REQ hash clients and sequences each client's multi-block message through the core. The first block of a message is issued with init=1 and later blocks with init=0. It watches core completion with a watchdog timer and reports per-client done or error. It sits between the client block buffers and the SHA512 core's control handshake. Data-path muxing of message words and digest is outside this block; the mux select is provided on sel.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
CNT_W, 8, width of per-job block count
TIMEOUT_CYC, 127, max cycles from core_sync to core_done before a job is aborted

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  per-client job request, level, sampled only at arbitration
req_mode  in  NUM_REQ*32  per-client SHA_Mode (224/256/512/other), slice k for client k
req_nblocks  in  NUM_REQ*CNT_W  per-client number of 1024-bit blocks in job
blk_avail  in  NUM_REQ  client k has next block staged
blk_take  out  NUM_REQ  one-cycle pulse, block consumed by core
gnt  out  NUM_REQ  one-hot owner of core, held for whole job
sel  out  $clog2(NUM_REQ)  binary index of owner
core_sync  out  1  one-cycle start strobe to SHA512 core
core_init  out  1  init flag to core, valid with core_sync
core_mode  out  32  SHA_Mode to core, held for whole job
core_done  in  1  one-cycle completion pulse from core
done  out  NUM_REQ  one-cycle job-complete pulse to owner
err  out  NUM_REQ  one-cycle job-abort pulse to owner

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; gnt, sel, core_init, core_mode, done, err, block counter and timer all 0.
  - rr_ptr=NUM_REQ-1, so client 0 has first priority.
  - Reset mid-job abandons the job silently; no err pulse.
- Outputs are registered, except core_sync and blk_take. Those two are combinational: asserted when state==ISSUE && blk_avail[sel].
- IDLE:
  - With req!=0, the winner is the first set bit searching from rr_ptr+1 with wrap-around.
  - Latch gnt, sel, core_mode=req_mode[sel], remaining=req_nblocks[sel], first=1.
  - Go to ISSUE, or to ERR if req_nblocks[sel]==0.
  - gnt is visible the cycle after req rises.
- ISSUE:
  - Stall while blk_avail[sel]=0.
  - When it is 1: core_sync=1 and blk_take[sel]=1 for exactly that cycle; core_init=first; clear timer; go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On core_done: remaining-=1 and first=0. If remaining was 1, go to DONE; else go to ISSUE.
  - If the timer reaches TIMEOUT_CYC with no core_done, go to ERR.
  - core_done in the same cycle as the timeout counts as done (done wins).
- DONE: done[sel]=1 for one cycle; gnt cleared; rr_ptr=sel; go to IDLE.
- ERR: err[sel]=1 for one cycle; gnt cleared; rr_ptr=sel; go to IDLE.
- Other rules:
  - A core_done outside WAIT is ignored.
  - Dropping req mid-job is ignored; the job runs to completion.
  - req_mode and req_nblocks changes after latching are ignored.
  - core_mode values other than 224/256/512 are passed through unchanged; the core applies its default IV path.
  - Minimum gap between jobs: 1 IDLE cycle.
  - remaining is unsigned CNT_W bits and never decrements below 1 before exit.

Decomposition:
- Package sha512_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE, ERR}
  - constants SHA_MODE_224=224, SHA_MODE_256=256, SHA_MODE_512=512
- Sub-module rr_arbiter (NUM_REQ): inputs req and ptr; outputs one-hot gnt, binary idx and any.

Test Plan:
- req=0001, nblocks=1, mode=512, blk_avail=1, core_done 82 cycles after core_sync -> gnt=0001 one cycle after req; single core_sync with init=1, core_mode=512; done[0] pulse one cycle after core_done; gnt=0.
- req=0001, nblocks=3, mode=256 -> three core_sync pulses with init=1,0,0 and mode=256; blk_take[0] coincides with each; exactly one done[0].
- req=1111 held after reset, each job nblocks=1 -> grant order 0,1,2,3. Then req=0101 -> order 0,2.
- req=0010, nblocks=0 -> err[1] pulse; no core_sync or blk_take.
- blk_avail[0]=0 for 10 cycles in ISSUE -> core_sync held off; it fires in the cycle blk_avail rises.
- core_done withheld, TIMEOUT_CYC=127 -> err[0] pulse at the 127th WAIT cycle. Repeat with core_done arriving in the timeout cycle -> done wins.
- rst=1 during WAIT of block 2 of 3 -> all outputs 0 immediately. After release, the same job re-issues with init=1.
